// File: rtl/instr_dispatcher.sv
// Instruction dispatcher: latches an opcode/argument set, routes it to the text or
// pixel execution unit, supervises completion with a timeout and reports status.
module instr_dispatcher #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   mode_control,
    input  logic [7:0]   instruction,
    input  logic [87:0]  arg_flat,
    input  logic         instruction_start,
    output logic         instruction_busy,
    output logic         instruction_finished,
    output logic         instruction_error,
    output logic [7:0]   result_0,
    output logic [7:0]   result_1,
    output logic [7:0]   unit_op,
    output logic [87:0]  unit_args,
    output logic         txt_start,
    output logic         pix_start,
    output logic         txt_abort,
    output logic         pix_abort,
    input  logic         txt_done,
    input  logic         pix_done,
    input  logic         txt_error,
    input  logic         pix_error,
    input  logic [15:0]  txt_result,
    input  logic [15:0]  pix_result
);

    // state    | meaning
    // IDLE     | waiting for instruction_start
    // DISPATCH | check routing/mode, pulse unit start, load timer
    // WAIT     | waiting for target unit done or timeout
    // COMPLETE | finished pulse, error status transferred next cycle
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_WAIT     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] timer;
    logic        fault;

    logic        accept;
    logic        is_txt_op;
    logic        is_pix_op;
    logic        legal;
    logic        tgt_done;
    logic        tgt_err;
    logic [15:0] tgt_result;
    logic        timer_zero;
    logic        keeps_result;

    logic        busy_d;
    logic        fin_d;
    logic        txt_start_d;
    logic        pix_start_d;
    logic        txt_abort_d;
    logic        pix_abort_d;

    assign accept       = (state == S_IDLE) && instruction_start;
    assign is_txt_op    = (unit_op <= 8'h03);
    assign is_pix_op    = (unit_op >= 8'h10) && (unit_op <= 8'h14);
    assign legal        = (is_txt_op && !mode_control[0]) || (is_pix_op && mode_control[0]);
    // Only legal opcodes reach WAIT, so the opcode alone selects the target unit.
    assign tgt_done     = is_pix_op ? pix_done   : txt_done;
    assign tgt_err      = is_pix_op ? pix_error  : txt_error;
    assign tgt_result   = is_pix_op ? pix_result : txt_result;
    assign timer_zero   = (timer == 16'd0);
    assign keeps_result = (unit_op == 8'h03) || (unit_op == 8'h14);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (instruction_start) state_nxt = S_DISPATCH;
            S_DISPATCH: state_nxt = legal ? S_WAIT : S_COMPLETE;
            S_WAIT:     if (tgt_done || timer_zero) state_nxt = S_COMPLETE;
            S_COMPLETE: state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; done takes priority over expiry.
    always_comb begin
        busy_d      = (state_nxt != S_IDLE);
        fin_d       = (state_nxt == S_COMPLETE);
        txt_start_d = (state == S_DISPATCH) && legal && is_txt_op;
        pix_start_d = (state == S_DISPATCH) && legal && is_pix_op;
        txt_abort_d = (state == S_WAIT) && !tgt_done && timer_zero && is_txt_op;
        pix_abort_d = (state == S_WAIT) && !tgt_done && timer_zero && is_pix_op;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instruction_busy     <= 1'b0;
            instruction_finished <= 1'b0;
            instruction_error    <= 1'b0;
            txt_start            <= 1'b0;
            pix_start            <= 1'b0;
            txt_abort            <= 1'b0;
            pix_abort            <= 1'b0;
            result_0             <= 8'h00;
            result_1             <= 8'h00;
            unit_op              <= 8'h00;
            unit_args            <= '0;
            timer                <= 16'd0;
            fault                <= 1'b0;
        end else begin
            instruction_busy     <= busy_d;
            instruction_finished <= fin_d;
            txt_start            <= txt_start_d;
            pix_start            <= pix_start_d;
            txt_abort            <= txt_abort_d;
            pix_abort            <= pix_abort_d;

            if (accept) begin
                unit_op           <= instruction;
                unit_args         <= arg_flat;
                fault             <= 1'b0;
                instruction_error <= 1'b0;
            end

            if (state == S_DISPATCH) begin
                timer <= TIMEOUT_CYCLES;
                fault <= !legal;
            end

            if (state == S_WAIT) begin
                if (tgt_done) begin
                    fault <= tgt_err;
                    if (!tgt_err && keeps_result) begin
                        result_0 <= tgt_result[7:0];
                        result_1 <= tgt_result[15:8];
                    end
                end else if (timer_zero) begin
                    fault <= 1'b1;
                end else begin
                    timer <= timer - 16'd1;
                end
            end

            if (state == S_COMPLETE) begin
                instruction_error <= fault;
            end
        end
    end

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: completions are checked against a scoreboard
// of expected results/error filled as each command is issued.
module tb_instr_dispatcher;

    localparam logic [15:0] TMO = 16'd8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   mode_control;
    logic [7:0]   instruction;
    logic [87:0]  arg_flat;
    logic         instruction_start;
    logic         instruction_busy;
    logic         instruction_finished;
    logic         instruction_error;
    logic [7:0]   result_0;
    logic [7:0]   result_1;
    logic [7:0]   unit_op;
    logic [87:0]  unit_args;
    logic         txt_start;
    logic         pix_start;
    logic         txt_abort;
    logic         pix_abort;
    logic         txt_done;
    logic         pix_done;
    logic         txt_error;
    logic         pix_error;
    logic [15:0]  txt_result;
    logic [15:0]  pix_result;

    instr_dispatcher #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .mode_control         (mode_control),
        .instruction          (instruction),
        .arg_flat             (arg_flat),
        .instruction_start    (instruction_start),
        .instruction_busy     (instruction_busy),
        .instruction_finished (instruction_finished),
        .instruction_error    (instruction_error),
        .result_0             (result_0),
        .result_1             (result_1),
        .unit_op              (unit_op),
        .unit_args            (unit_args),
        .txt_start            (txt_start),
        .pix_start            (pix_start),
        .txt_abort            (txt_abort),
        .pix_abort            (pix_abort),
        .txt_done             (txt_done),
        .pix_done             (pix_done),
        .txt_error            (txt_error),
        .pix_error            (pix_error),
        .txt_result           (txt_result),
        .pix_result           (pix_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r0;
        logic [7:0] r1;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fin = 0, n_txt_start = 0, n_pix_start = 0, n_txt_abort = 0, n_pix_abort = 0;

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (txt_start) n_txt_start++;
            if (pix_start) n_pix_start++;
            if (txt_abort) n_txt_abort++;
            if (pix_abort) n_pix_abort++;
        end
    end

    // Completion monitor: results at the finished pulse, error one cycle later.
    always @(negedge clk) begin
        if (reset_n && instruction_finished) begin
            exp_t e;
            n_fin++;
            chk("sb_has_entry", 88'(sb.size() != 0), 88'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result_0", 88'(result_0), 88'(e.r0));
                chk("result_1", 88'(result_1), 88'(e.r1));
                @(negedge clk);
                chk("error_after_complete", 88'(instruction_error), 88'(e.err));
                chk("busy_after_complete", 88'(instruction_busy), 88'd0);
            end
        end
    end

    task automatic push_exp(input logic [7:0] r0, input logic [7:0] r1, input logic err);
        exp_t e;
        e.r0 = r0; e.r1 = r1; e.err = err;
        sb.push_back(e);
    endtask

    // Returns one cycle after acceptance (DISPATCH); inputs are scrambled afterwards.
    task automatic start_cmd(input logic [7:0] op, input logic [87:0] args);
        instruction       = op;
        arg_flat          = args;
        instruction_start = 1'b1;
        tick();
        instruction_start = 1'b0;
        instruction       = 8'hEE;
        arg_flat          = ~args;
    endtask

    task automatic wait_finished(input int budget, output int n);
        n = 0;
        while (!instruction_finished && n < budget) begin
            tick();
            n++;
        end
        chk("finished_within_budget", 88'(instruction_finished), 88'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},   88'(instruction_busy),     88'd0);
        chk({tag, "_fin"},    88'(instruction_finished), 88'd0);
        chk({tag, "_err"},    88'(instruction_error),    88'd0);
        chk({tag, "_starts"}, 88'({txt_start, pix_start}), 88'd0);
        chk({tag, "_aborts"}, 88'({txt_abort, pix_abort}), 88'd0);
        chk({tag, "_r0"},     88'(result_0), 88'd0);
        chk({tag, "_r1"},     88'(result_1), 88'd0);
        chk({tag, "_op"},     88'(unit_op),  88'd0);
        chk({tag, "_args"},   unit_args,     88'd0);
    endtask

    initial begin
        logic [87:0] args_a;
        logic [87:0] args_b;
        int n;
        int fin0, ab0, ps0, ts0;

        args_a = 88'h0A_0908_0706_0504_0302_0100;
        args_b = 88'hDE_ADBE_EF01_2345_6789_ABCD;
        reset_n = 1'b0;
        mode_control = 8'h00; instruction = 8'h00; arg_flat = '0; instruction_start = 1'b0;
        txt_done = 1'b0; pix_done = 1'b0; txt_error = 1'b0; pix_error = 1'b0;
        txt_result = 16'h0000; pix_result = 16'h0000;
        tick(); tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Text op 0x03, done 5 cycles after txt_start, result 0x4142.
        mode_control = 8'h00;
        push_exp(8'h42, 8'h41, 1'b0);
        start_cmd(8'h03, args_a);
        chk("t1_busy_dispatch", 88'(instruction_busy), 88'd1);
        chk("t1_err_cleared", 88'(instruction_error), 88'd0);
        tick();
        chk("t1_txt_start", 88'(txt_start), 88'd1);
        chk("t1_unit_op", 88'(unit_op), 88'h03);
        chk("t1_unit_args", unit_args, args_a);
        repeat (5) tick();
        txt_done = 1'b1; txt_result = 16'h4142; txt_error = 1'b0;
        chk("t1_fin_before_done", 88'(instruction_finished), 88'd0);
        tick();
        txt_done = 1'b0; txt_result = 16'hFFFF;
        chk("t1_fin_latency", 88'(instruction_finished), 88'd1);
        chk("t1_txt_start_count", 88'(n_txt_start), 88'd1);
        tick(); tick();

        // Pixel op in text mode: rejected, no unit start.
        ps0 = n_pix_start;
        push_exp(8'h42, 8'h41, 1'b1);
        start_cmd(8'h10, args_b);
        tick();
        chk("t2_fin_latency", 88'(instruction_finished), 88'd1);
        chk("t2_err_not_yet", 88'(instruction_error), 88'd0);
        tick();
        chk("t2_err_set", 88'(instruction_error), 88'd1);
        repeat (3) tick();
        chk("t2_err_held", 88'(instruction_error), 88'd1);
        chk("t2_no_pix_start", 88'(n_pix_start), 88'(ps0));

        // Pixel op 0x13 that never completes: timeout and abort.
        mode_control = 8'h01;
        ab0 = n_pix_abort;
        push_exp(8'h42, 8'h41, 1'b1);
        start_cmd(8'h13, args_a);
        chk("t3_err_cleared_on_start", 88'(instruction_error), 88'd0);
        tick();
        chk("t3_pix_start", 88'(pix_start), 88'd1);
        wait_finished(40, n);
        chk("t3_timeout_cycles", 88'(n), 88'(TMO + 16'd1));
        chk("t3_abort_with_fin", 88'(pix_abort), 88'd1);
        tick(); tick();
        chk("t3_pix_abort_count", 88'(n_pix_abort), 88'(ab0 + 1));
        chk("t3_no_txt_abort", 88'(n_txt_abort), 88'd0);

        // Second start and a stray txt_done during WAIT are ignored.
        ts0 = n_txt_start;
        push_exp(8'h42, 8'h41, 1'b0);
        start_cmd(8'h11, args_b);
        tick();
        instruction = 8'h02; arg_flat = args_a; instruction_start = 1'b1;
        tick();
        instruction_start = 1'b0;
        txt_done = 1'b1; txt_result = 16'hFFFF;
        tick();
        txt_done = 1'b0;
        tick();
        chk("t4_still_busy", 88'(instruction_busy), 88'd1);
        chk("t4_no_fin", 88'(instruction_finished), 88'd0);
        chk("t4_op_stable", 88'(unit_op), 88'h11);
        chk("t4_args_stable", unit_args, args_b);
        pix_done = 1'b1; pix_result = 16'h7777; pix_error = 1'b0;
        tick();
        pix_done = 1'b0;
        chk("t4_fin_on_pix_done", 88'(instruction_finished), 88'd1);
        chk("t4_no_txt_start", 88'(n_txt_start), 88'(ts0));
        tick(); tick();

        // pix_done in the same cycle the timer reaches zero: done wins.
        ab0 = n_pix_abort;
        push_exp(8'h42, 8'h41, 1'b1);
        start_cmd(8'h14, args_a);
        tick();
        repeat (int'(TMO)) tick();
        pix_done = 1'b1; pix_error = 1'b1; pix_result = 16'h5555;
        tick();
        pix_done = 1'b0; pix_error = 1'b0;
        chk("t5_fin", 88'(instruction_finished), 88'd1);
        chk("t5_no_abort_pulse", 88'(pix_abort), 88'd0);
        tick(); tick();
        chk("t5_abort_count", 88'(n_pix_abort), 88'(ab0));

        // Op 0x14 success updates results.
        push_exp(8'h64, 8'h63, 1'b0);
        start_cmd(8'h14, args_b);
        tick(); tick();
        pix_done = 1'b1; pix_result = 16'h6364;
        tick();
        pix_done = 1'b0; pix_result = 16'h0000;
        chk("t6_fin", 88'(instruction_finished), 88'd1);
        tick(); tick();

        // Text opcode in graphics mode: mismatch.
        push_exp(8'h64, 8'h63, 1'b1);
        start_cmd(8'h02, args_a);
        tick();
        chk("t7_fin", 88'(instruction_finished), 88'd1);
        chk("t7_no_txt_start", 88'(txt_start), 88'd0);
        tick(); tick();

        // Reset during WAIT abandons the command.
        fin0 = n_fin; ab0 = n_pix_abort;
        start_cmd(8'h13, args_b);
        tick(); tick(); tick();
        reset_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        tick(); tick();
        reset_n = 1'b1;
        repeat (int'(TMO) + 4) tick();
        chk("t8_no_fin", 88'(n_fin), 88'(fin0));
        chk("t8_no_abort", 88'(n_pix_abort), 88'(ab0));
        push_exp(8'h00, 8'h00, 1'b0);
        start_cmd(8'h12, args_a);
        tick();
        chk("t8_pix_start", 88'(pix_start), 88'd1);
        chk("t8_op", 88'(unit_op), 88'h12);
        tick();
        pix_done = 1'b1; pix_result = 16'h9999;
        tick();
        pix_done = 1'b0;
        chk("t8_fin", 88'(instruction_finished), 88'd1);
        tick(); tick(); tick();

        chk("sb_drained", 88'(sb.size()), 88'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
